// File: rtl/ysyx_23060229_axi_pkg.sv
// Shared definitions for the ysyx_23060229 AXI4 initiator.
//   axi_state_e     : initiator FSM states (IDLE, AR, R, WR, B)
//   AXI_BURST_INCR  : INCR burst encoding
//   AXI_RESP_OKAY   : OKAY response encoding
//   AXI_SIZE_WORD   : widest beat this 32-bit bus supports (4 bytes)
//   clamp_size()    : limits a requested beat size to AXI_SIZE_WORD
package ysyx_23060229_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4
  } axi_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > AXI_SIZE_WORD) ? AXI_SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/ysyx_23060229_axi_wr_chan.sv
// AW/W issue tracker for a single-beat write.
// While `active` is high, awvalid and wvalid are raised together; each one
// drops on its own after its handshake, remembered in aw_done / w_done.
// `done` goes high in the cycle the second (or both) handshake completes.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   active            : initiator is in its write-address/data phase
//   awready, wready   : responder readies
//   awvalid, wvalid   : initiator valids for AW and W
//   done              : both handshakes complete (this cycle or earlier)
module ysyx_23060229_axi_wr_chan (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic done
);

  logic aw_done;
  logic w_done;

  assign awvalid = active && !aw_done;
  assign wvalid  = active && !w_done;
  // A handshake in the current cycle counts the same as a recorded one, so
  // simultaneous AW and W acceptance finishes in a single cycle.
  assign done    = active && (aw_done || awready) && (w_done || wready);

  always_ff @(posedge clock) begin
    if (reset || !active || done) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060229_axi4_master.sv
// AXI4 initiator bridge: one request at a time, either an INCR read burst of
// 1..256 beats or a single-beat write, returned on a registered response port.
//
// Handshake rule on every channel (req_* and all io_master_* channels): a
// transfer happens on a rising edge where valid and ready are both high; a
// valid, once raised, stays high with a stable payload until that transfer.
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   req_*               : request (valid/ready, wen, addr, len=beats-1, size,
//                         wdata, wstrb); len is ignored for writes
//   rsp_*               : one-cycle pulse per read beat or write completion
//                         with data (0 for writes), last and err flags; no
//                         back-pressure
//   io_master_ar/r/aw/w/b* : AXI4 initiator channels, ids fixed to AXI_ID
//   dbg_state           : current FSM state
// Build option: YSYX_23060229_AXI_RESP_CHECK_EN enables rsp_err reporting of
// bad resp/id codes and rlast/beat-count disagreement; without it rsp_err is 0
// and the R phase ends only on rlast.
module ysyx_23060229_axi4_master
  import ysyx_23060229_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [31:0] io_master_rdata,
  input  logic [1:0]  io_master_rresp,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  input  logic        io_master_bvalid,
  output logic        io_master_bready,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  output axi_state_e  dbg_state
);

  axi_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [8:0]  beat_q;   // one bit wider than arlen so overrun beats compare correctly
  logic        wr_active;
  logic        wr_done;
  logic        r_err;
  logic        b_err;
  logic        req_hs;

  assign dbg_state = state_q;
  assign req_hs    = req_valid && req_ready;

  // Address/data payloads come straight from the latches, so they cannot
  // change while a valid is pending.
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;

  ysyx_23060229_axi_wr_chan u_wr_chan (
    .clock   (clock),
    .reset   (reset),
    .active  (wr_active),
    .awready (io_master_awready),
    .wready  (io_master_wready),
    .awvalid (io_master_awvalid),
    .wvalid  (io_master_wvalid),
    .done    (wr_done)
  );

`ifdef YSYX_23060229_AXI_RESP_CHECK_EN
  always_comb begin
    r_err = (io_master_rresp != AXI_RESP_OKAY) || (io_master_rid != AXI_ID);
    // rlast must land exactly on beat arlen; any beat at or past arlen
    // without rlast is an overrun.
    if (io_master_rlast) r_err = r_err || (beat_q != {1'b0, len_q});
    else                 r_err = r_err || (beat_q >= {1'b0, len_q});
    b_err = (io_master_bresp != AXI_RESP_OKAY) || (io_master_bid != AXI_ID);
  end
`else
  assign r_err = 1'b0;
  assign b_err = 1'b0;
  logic unused_resp_fields;
  assign unused_resp_fields = ^{io_master_rresp, io_master_rid, io_master_bresp,
                                io_master_bid, beat_q};
`endif

  always_comb begin
    state_d           = state_q;
    req_ready         = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_bready  = 1'b0;
    wr_active         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_wen ? ST_WR : ST_AR;
      end
      ST_AR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) state_d = ST_R;
      end
      ST_R: begin
        io_master_rready = 1'b1;
        if (io_master_rvalid && io_master_rlast) state_d = ST_IDLE;
      end
      ST_WR: begin
        wr_active = 1'b1;
        if (wr_done) state_d = ST_B;
      end
      ST_B: begin
        io_master_bready = 1'b1;
        if (io_master_bvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // No request may be taken while reset is being applied.
    if (reset) req_ready = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      beat_q    <= 9'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (req_hs) begin
        addr_q  <= req_addr;
        len_q   <= req_wen ? 8'd0 : req_len;
        size_q  <= clamp_size(req_size);
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        beat_q  <= 9'd0;
      end
      if (state_q == ST_R && io_master_rvalid) begin
        rsp_valid <= 1'b1;
        rsp_data  <= io_master_rdata;
        rsp_last  <= io_master_rlast;
        rsp_err   <= r_err;
        beat_q    <= beat_q + 9'd1;
      end
      if (state_q == ST_B && io_master_bvalid) begin
        rsp_valid <= 1'b1;
        rsp_data  <= 32'd0;
        rsp_last  <= 1'b1;
        rsp_err   <= b_err;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060229_axi4_master.sv
`timescale 1ns/1ps
module tb_ysyx_23060229_axi4_master;
  import ysyx_23060229_axi_pkg::*;

`ifdef YSYX_23060229_AXI_RESP_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        io_master_arvalid;
  logic        io_master_arready = 1'b0;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid = 1'b0;
  logic        io_master_rready;
  logic [31:0] io_master_rdata = '0;
  logic [1:0]  io_master_rresp = '0;
  logic        io_master_rlast = 1'b0;
  logic [3:0]  io_master_rid = '0;
  logic        io_master_awvalid;
  logic        io_master_awready = 1'b0;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_wvalid;
  logic        io_master_wready = 1'b0;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_wlast;
  logic        io_master_bvalid = 1'b0;
  logic        io_master_bready;
  logic [1:0]  io_master_bresp = '0;
  logic [3:0]  io_master_bid = '0;
  axi_state_e  dbg_state;

  ysyx_23060229_axi4_master #(.AXI_ID(4'd0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- responder model ----------------
  logic [31:0] mem [0:255];
  int          ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  int          early_last = -1;
  logic        rd_active = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [7:0]  rd_len = '0, rd_beat = '0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_strb = '0;
  int          aw_hi_cnt = 0, w_hi_cnt = 0;
  logic [31:0] seen_araddr = '0;
  logic [7:0]  seen_arlen = '0, seen_awlen = '0;
  logic [2:0]  seen_arsize = '0;
  logic [1:0]  seen_arburst = '0;
  logic [3:0]  seen_arid = '0;
  logic        seen_wlast = 1'b0;

  // Runs at the falling edge: DUT outputs are settled, and the values driven
  // here are what the DUT samples at the next rising edge.
  task automatic resp_step();
    logic [7:0] idx;
    if (reset) begin
      rd_active = 0; rd_beat = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0;
      io_master_arready = 0; io_master_rvalid = 0; io_master_rlast = 0;
      io_master_awready = 0; io_master_wready = 0; io_master_bvalid = 0;
      return;
    end
    io_master_rvalid = 0;
    io_master_rlast  = 0;
    if (rd_active) begin
      idx = rd_addr[9:2] + rd_beat;
      io_master_rvalid = 1;
      io_master_rdata  = mem[idx];
      io_master_rresp  = 2'b00;
      io_master_rlast  = (rd_beat == rd_len) || (early_last >= 0 && int'(rd_beat) == early_last);
      if (io_master_rready) begin
        if (io_master_rlast) begin rd_active = 0; rd_beat = 0; end
        else rd_beat = rd_beat + 8'd1;
      end
    end
    io_master_arready = 0;
    if (!rd_active && io_master_arvalid) begin
      if (ar_cnt >= ar_delay) begin
        io_master_arready = 1; rd_active = 1; ar_cnt = 0; rd_beat = 0;
        rd_addr = io_master_araddr; rd_len = io_master_arlen;
        seen_araddr = io_master_araddr; seen_arlen = io_master_arlen;
        seen_arsize = io_master_arsize; seen_arburst = io_master_arburst;
        seen_arid = io_master_arid;
      end else ar_cnt++;
    end
    if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
    io_master_bvalid = 0;
    if (b_pend) begin
      io_master_bvalid = 1;
      io_master_bresp  = cfg_bresp;
      if (io_master_bready) begin
        for (int k = 0; k < 4; k++)
          if (wr_strb[k]) mem[wr_addr[9:2]][k*8 +: 8] = wr_data[k*8 +: 8];
        b_pend = 0;
      end
    end
    io_master_awready = 0;
    if (io_master_awvalid && !aw_got) begin
      aw_hi_cnt++;
      if (aw_cnt >= aw_delay) begin
        io_master_awready = 1; aw_got = 1; aw_cnt = 0;
        wr_addr = io_master_awaddr; seen_awlen = io_master_awlen;
      end else aw_cnt++;
    end
    io_master_wready = 0;
    if (io_master_wvalid && !w_got) begin
      w_hi_cnt++;
      if (w_cnt >= w_delay) begin
        io_master_wready = 1; w_got = 1; w_cnt = 0;
        wr_data = io_master_wdata; wr_strb = io_master_wstrb; seen_wlast = io_master_wlast;
      end else w_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      resp_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [31:0] wd, input logic [3:0] ws,
                       output logic ok);
    int t;
    ok = 0; t = 0;
    req_valid = 1; req_wen = wen; req_addr = addr; req_len = len;
    req_size = size; req_wdata = wd; req_wstrb = ws;
    while (!req_ready && t < 20) begin @(posedge clock); #1; t++; end
    if (req_ready) begin @(posedge clock); #1; ok = 1; end
    req_valid = 0; req_wen = 0;
  endtask

  task automatic wait_rsp(input int budget, output int lat, output logic found);
    lat = 0; found = 0;
    while (!found && lat < budget) begin
      @(posedge clock); #1; lat++;
      if (rsp_valid) found = 1;
    end
  endtask

  // Single-word read returning one response; checks data and latency.
  task automatic read_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic ok, found;
    int lat;
    issue(1'b0, addr, 8'd0, 3'd2, 32'd0, 4'd0, ok);
    wait_rsp(10, lat, found);
    checks++;
    if (!ok || !found || lat != 2)
      begin errors++; $display("FAIL %s_latency: ok=%0b found=%0b lat=%0d required 2", name, ok, found, lat); end
    checks++;
    if ({rsp_data, rsp_last, rsp_err} !== {exp, 1'b1, 1'b0})
      begin errors++; $display("FAIL %s_data: got %h last=%0b err=%0b required %h last=1 err=0", name, rsp_data, rsp_last, rsp_err, exp); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({req_ready, io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid,
         io_master_bready, rsp_valid, rsp_data, rsp_last, rsp_err} !== '0)
      begin errors++; $display("FAIL reset_outputs: req_ready=%0b arvalid=%0b rready=%0b awvalid=%0b wvalid=%0b bready=%0b rsp_valid=%0b rsp_data=%h required all 0",
        req_ready, io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid, io_master_bready, rsp_valid, rsp_data); end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    reset = 0;
    @(posedge clock); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", req_ready); end
  endtask

  task automatic test_single_read();
    read_word("rd_single", 32'h8000_0000, 32'hDEAD_BEEF);
    checks++;
    if ({seen_araddr, seen_arlen, seen_arburst, seen_arsize, seen_arid} !== {32'h8000_0000, 8'd0, 2'b01, 3'd2, 4'd0})
      begin errors++; $display("FAIL rd_single_ar: addr=%h len=%0d burst=%b size=%0d id=%0d required 80000000/0/01/2/0",
        seen_araddr, seen_arlen, seen_arburst, seen_arsize, seen_arid); end
    @(posedge clock); #1;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01)
      begin errors++; $display("FAIL rd_single_after: rsp_valid=%0b req_ready=%0b required 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_burst_read();
    logic ok;
    int n, rdy_bad, data_bad, last_bad, t;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA500_0040 + i);
    issue(1'b0, 32'h8000_0100, 8'd7, 3'd2, 32'd0, 4'd0, ok);
    n = 0; rdy_bad = 0; data_bad = 0; last_bad = 0; t = 0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL burst_ready_after_accept: got %0b required 0", req_ready); end
    while (t < 40) begin
      @(posedge clock); #1; t++;
      if (rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        if (rsp_data !== e) begin data_bad++; $display("FAIL burst_data: beat %0d got %h required %h", n, rsp_data, e); end
        if (rsp_last !== (n == 7)) last_bad++;
        n++;
        if (rsp_last) begin
          if (req_ready !== 1'b1) rdy_bad++;
          break;
        end
      end
      if (req_ready !== 1'b0) rdy_bad++;
    end
    checks++;
    if (!ok || n != 8) begin errors++; $display("FAIL burst_count: ok=%0b beats=%0d required 8", ok, n); end
    checks++;
    if (data_bad != 0) errors++;
    checks++;
    if (last_bad != 0) begin errors++; $display("FAIL burst_last: %0d beats with wrong rsp_last required 0", last_bad); end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL burst_req_ready: %0d bad samples required 0", rdy_bad); end
    exp_q.delete();
  endtask

  task automatic test_write_skew();
    logic ok, found;
    int lat, extra;
    aw_delay = 3; w_delay = 0; aw_hi_cnt = 0; w_hi_cnt = 0;
    issue(1'b1, 32'h8000_0010, 8'h55, 3'd2, 32'h1234_5678, 4'b0011, ok);
    wait_rsp(20, lat, found);
    checks++;
    if (!ok || !found || lat != 5)
      begin errors++; $display("FAIL wr_latency: ok=%0b found=%0b lat=%0d required 5", ok, found, lat); end
    checks++;
    if ({rsp_data, rsp_last, rsp_err} !== {32'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL wr_rsp: data=%h last=%0b err=%0b required 0 1 0", rsp_data, rsp_last, rsp_err); end
    checks++;
    if (aw_hi_cnt != 4 || w_hi_cnt != 1)
      begin errors++; $display("FAIL wr_valid_cycles: awvalid=%0d wvalid=%0d required 4 1", aw_hi_cnt, w_hi_cnt); end
    checks++;
    if ({seen_awlen, seen_wlast} !== {8'd0, 1'b1})
      begin errors++; $display("FAIL wr_len_last: awlen=%0d wlast=%0b required 0 1", seen_awlen, seen_wlast); end
    extra = 0;
    repeat (5) begin @(posedge clock); #1; if (rsp_valid) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL wr_single_rsp: %0d extra pulses required 0", extra); end
    aw_delay = 0;
    read_word("wr_readback", 32'h8000_0010, 32'hA500_5678);
  endtask

  task automatic test_size_clamp();
    logic ok, found;
    int lat;
    issue(1'b0, 32'h8000_0004, 8'd0, 3'd3, 32'd0, 4'd0, ok);
    wait_rsp(10, lat, found);
    checks++;
    if (seen_arsize !== 3'd2) begin errors++; $display("FAIL size_clamp: arsize=%0d required 2", seen_arsize); end
    checks++;
    if (!found || rsp_data !== 32'hA500_0001)
      begin errors++; $display("FAIL size_clamp_data: found=%0b got %h required a5000001", found, rsp_data); end
  endtask

  task automatic test_back_to_back();
    read_word("b2b_first", 32'h8000_0014, 32'hA500_0005);
    read_word("b2b_second", 32'h8000_0018, 32'hA500_0006);
  endtask

  task automatic test_resp_err();
    logic ok, found;
    int lat, n, t;
    logic [2:0] errs, lasts;
    cfg_bresp = 2'b10;
    issue(1'b1, 32'h8000_0030, 8'd0, 3'd2, 32'hCAFE_0001, 4'b1111, ok);
    wait_rsp(10, lat, found);
    checks++;
    if (!found || rsp_err !== ERR_EN)
      begin errors++; $display("FAIL err_bresp: found=%0b err=%0b required %0b", found, rsp_err, ERR_EN); end
    cfg_bresp = 2'b00;
    early_last = 2;
    issue(1'b0, 32'h8000_0020, 8'd3, 3'd2, 32'd0, 4'd0, ok);
    n = 0; t = 0; errs = '0; lasts = '0;
    while (t < 20 && n < 3) begin
      @(posedge clock); #1; t++;
      if (rsp_valid) begin errs[n] = rsp_err; lasts[n] = rsp_last; n++; end
    end
    checks++;
    if (n != 3 || errs !== {ERR_EN, 2'b00} || lasts !== 3'b100)
      begin errors++; $display("FAIL err_early_rlast: beats=%0d err=%b last=%b required 3 %b 100", n, errs, lasts, {ERR_EN, 2'b00}); end
    checks++;
    if (dbg_state !== ST_IDLE || req_ready !== 1'b1)
      begin errors++; $display("FAIL err_early_idle: state=%0d req_ready=%0b required 0 1", dbg_state, req_ready); end
    early_last = -1;
  endtask

  task automatic test_reset_mid_burst();
    logic ok;
    int n, t;
    logic [31:0] got [0:3];
    issue(1'b0, 32'h8000_0000, 8'd15, 3'd2, 32'd0, 4'd0, ok);
    n = 0; t = 0;
    while (t < 30 && n < 4) begin
      @(posedge clock); #1; t++;
      if (rsp_valid) begin got[n] = rsp_data; n++; end
    end
    checks++;
    if (n != 4 || got[0] !== 32'hDEAD_BEEF || got[1] !== 32'hA500_0001 ||
        got[2] !== 32'hA500_0002 || got[3] !== 32'hA500_0003)
      begin errors++; $display("FAIL midrst_beats: beats=%0d first=%h last=%h required 4 deadbeef a5000003", n, got[0], got[3]); end
    reset = 1;
    @(posedge clock); #1;
    checks++;
    if ({req_ready, io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid,
         io_master_bready, rsp_valid} !== 7'b0 || dbg_state !== ST_IDLE)
      begin errors++; $display("FAIL midrst_outputs: ready/valids=%b state=%0d required 0000000 0",
        {req_ready, io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid, io_master_bready, rsp_valid}, dbg_state); end
    reset = 0;
    @(posedge clock); #1;
    read_word("midrst_after", 32'h8000_0008, 32'hA500_0002);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
    mem[0] = 32'hDEAD_BEEF;
    test_reset();
    test_single_read();
    test_burst_read();
    test_write_skew();
    test_size_clamp();
    test_back_to_back();
    test_resp_err();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_23060229_axi4_master.md
# ysyx_23060229_axi4_master

AXI4 initiator bridge between the core's internal memory-request port and the `io_master_*` AXI4 bus that the non-SoC memory model and SoC crossbar respond on. It accepts one request at a time: an INCR read burst of 1–256 beats, or a single-beat write. It drives all five AXI channels and returns read beats and write completions on a registered response port. It is the initiator counterpart of `ysyx_23060229_memory`, for use by the I-cache refill, LSU and future DMA.

## Interface

**Parameters**
- `AXI_ID`, default 4'd0: constant value driven on `arid`/`awid` and expected on `rid`/`bid`.

**Ports** (`name direction width meaning`)
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both are high.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_len` in 8: beats−1. Reads only; writes ignore it and use 0.
- `req_size` in 3: log2 bytes per beat.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: write strobes.
- `rsp_valid` out 1: one-cycle pulse per read beat or write completion.
- `rsp_data` out 32: read data (0 for writes).
- `rsp_last` out 1: final beat of the request.
- `rsp_err` out 1: error on this beat.
- `io_master_ar*`: `arvalid`/`arready`/`araddr[31:0]`/`arid[3:0]`/`arlen[7:0]`/`arsize[2:0]`/`arburst[1:0]`, direction per AXI4 initiator.
- `io_master_r*`: `rvalid`/`rready`/`rdata[31:0]`/`rresp[1:0]`/`rlast`/`rid[3:0]`.
- `io_master_aw*`: same fields as AR.
- `io_master_w*`: `wvalid`/`wready`/`wdata[31:0]`/`wstrb[3:0]`/`wlast`.
- `io_master_b*`: `bvalid`/`bready`/`bresp[1:0]`/`bid[3:0]`.

## Operation

**States:** IDLE, AR, R, WR, B.
- **IDLE**
  - `req_ready=1`.
  - On accept, latch all request fields. Go to AR if `req_wen=0`, else WR.
- **AR**
  - `arvalid=1`. `araddr`/`arlen`/`arsize` come from the latches; `arburst=2'b01`.
  - Go to R on `arready`.
- **R**
  - `rready=1`, held constant.
  - Each `rvalid` beat is registered into `rsp_*` and the beat counter increments.
  - Leave for IDLE on the beat where `rlast=1`.
- **WR**
  - `awvalid` and `wvalid` rise together, with `awlen=0` and `wlast=1`.
  - Each valid drops independently after its own handshake; flags `aw_done`/`w_done` track this.
  - Go to B when both handshakes are complete. Same-cycle completion is legal.
- **B**
  - `bready=1`.
  - On `bvalid`: `rsp_valid=1` next cycle, with `rsp_last=1` and `rsp_data=0`. Go to IDLE.

**Field handling**
- `req_size>3'd2` is clamped to 3'd2.
- 4 KB boundary crossing is not checked; the requester guarantees it.

**Response consumer**
- The consumer has no back-pressure and must accept every `rsp_valid` pulse.

**Reset**
- Reset in any state returns to IDLE at the next edge.
- All `*valid` and `*ready` outputs are 0, and `rsp_*`, counters and latches are 0.
- An in-flight transaction is abandoned. This is legal because the responder shares the same reset.

## Timing

- **Read, ideal responder:**
  - accept at cycle 0, `arvalid` at cycle 1;
  - first R beat at cycle 2 at the earliest, `rsp_valid` at cycle 3;
  - the pipeline then delivers one beat per cycle.
- **Write, ideal responder:**
  - accept at cycle 0, AW+W at cycle 1, B at cycle 2, `rsp_valid` at cycle 3.
- **Back-to-back:** `req_ready` reasserts in the cycle after the last R or B handshake. There is no overlap between requests.
- **Valid stability:** `arvalid`, `awvalid` and `wvalid` never drop before their handshake, and their payloads stay stable while valid.
- **Response latency:** fixed at 1 cycle after the R/B handshake.

## Configuration

`YSYX_23060229_AXI_RESP_CHECK_EN`

**Defined:** `rsp_err=1` on a beat when any of these holds:
- `rresp` or `bresp` is not 2'b00;
- `rid` or `bid` does not equal `AXI_ID`;
- `rlast` arrives with beat count ≠ `arlen`;
- beat count reaches `arlen` without `rlast`.

In the last case the block stays in R and keeps accepting beats until `rlast`.

**Undefined:**
- `rsp_err` is tied to 0 and id/resp are ignored.
- Only `rlast` terminates R.

## Structure

- **Shared package `ysyx_23060229_axi_pkg`:**
  - state enum;
  - `AXI_BURST_INCR=2'b01`;
  - `AXI_RESP_OKAY=2'b00`;
  - `AXI_SIZE_WORD=3'd2`.
- **Sub-module `ysyx_23060229_axi_wr_chan`:** handles the AW/W done-flag tracking.
- Everything else is flat.

## Test plan

- **Single read:** read `req_len=0` at `0x8000_0000` against `ysyx_23060229_memory` holding `0xDEADBEEF` → `arlen=0`, `arburst=01`, one `rsp_valid` with `rsp_data=0xDEADBEEF`, `rsp_last=1`.
- **Burst read:** `req_len=7` at `0x8000_0100` → 8 pulses with consecutive words and `rsp_last` only on the 8th. `req_ready` is low throughout and returns 1 cycle after the final beat.
- **Write skew:** write `0x1234_5678`, `wstrb=4'b0011`, with `awready` delayed 3 cycles and `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` after 4. A single `rsp_valid` follows B, and readback gives the low half updated.
- **Error check (macro defined):** with `bresp=2'b10` → `rsp_err=1`. With a stub asserting `rlast` on beat 2 of a `len=3` read → `rsp_err=1` on beat 2 and return to IDLE.
- **Reset mid-burst:** reset asserted mid-burst at beat 4 of `len=15` → next edge all valids/readies 0, state IDLE. After release, a new read completes correctly.
- **Size clamp:** `req_size=3'd3` → `arsize=3'd2`.
